// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Receives a program image over an 8N1 UART line and turns it into write
// strobes for a program memory. Bytes arrive in HI/LO pairs: the HI byte
// carries the opcode in its low INSTRUCTION_WIDTH bits and the LO byte carries
// the operand in its low ADDR_WIDTH bits. A 0xFF in the HI position ends the
// download and rewinds the write address to zero.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   rx             asynchronous UART serial input, idle high
//   program_write  one-cycle write strobe to the program memory
//   program_cmd    assembled {opcode, operand} word, valid with program_write
//   write_address  target address, valid with program_write
//   loading        high while a download is in progress
//   frame_error    one-cycle pulse when a stop bit is sampled low

module uart_program_loader #(
  parameter int CLK_DIV           = 868,
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  loading,
  output logic                  frame_error
);

  localparam int CNT_WIDTH = $clog2(CLK_DIV + 1);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(CLK_DIV);
  localparam logic [CNT_WIDTH-1:0] HALF_COUNT = CNT_WIDTH'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    PHASE_HI,
    PHASE_LO
  } phase_t;

  rx_state_t state, state_next;
  phase_t    phase;

  logic                         rx_meta, rx_sync, rx_prev;
  logic [CNT_WIDTH-1:0]         cnt, cnt_next;
  logic [2:0]                   bit_idx, bit_next;
  logic [7:0]                   shift_reg, shift_next;
  logic                         expire;
  logic                         stop_ok, stop_bad;
  logic [INSTRUCTION_WIDTH-1:0] opcode;
  logic [ADDR_WIDTH-1:0]        address;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  // All stages reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // The counter expires when it is about to reach zero, so a load of N gives
  // exactly N cycles: half a bit to reach the start-bit centre, then a full
  // bit between subsequent samples.
  assign expire = (cnt == CNT_WIDTH'(1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = START;
          cnt_next   = HALF_COUNT;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_sync) begin
            state_next = DATA;
            cnt_next   = FULL_COUNT;
            bit_next   = 3'd0;
          end else begin
            // Line was high again at mid start bit: treat it as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (expire) begin
          shift_next = {rx_sync, shift_reg[7:1]};
          cnt_next   = FULL_COUNT;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - CNT_WIDTH'(1);
        end
      end
      STOP: begin
        if (expire) begin
          stop_ok    = rx_sync;
          stop_bad   = !rx_sync;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word assembler. It acts directly on the stop-bit sample so the write
  // strobe lands one cycle after it. The address advances the cycle after a
  // strobe, while write_address keeps the value that was written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase         <= PHASE_HI;
      opcode        <= '0;
      address       <= '0;
      program_cmd   <= '0;
      write_address <= '0;
      program_write <= 1'b0;
      loading       <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      program_write <= 1'b0;
      frame_error   <= 1'b0;
      if (program_write) begin
        address <= address + ADDR_WIDTH'(1);
      end
      if (stop_bad) begin
        // A corrupted byte resynchronises the pair on the next byte.
        frame_error <= 1'b1;
        phase       <= PHASE_HI;
      end else if (stop_ok) begin
        if (phase == PHASE_HI) begin
          if (shift_reg == 8'hFF) begin
            loading <= 1'b0;
            address <= '0;
          end else begin
            opcode  <= INSTRUCTION_WIDTH'(shift_reg);
            loading <= 1'b1;
            phase   <= PHASE_LO;
          end
        end else begin
          program_cmd   <= DATA_WIDTH'({opcode, ADDR_WIDTH'(shift_reg)});
          write_address <= address;
          program_write <= 1'b1;
          phase         <= PHASE_HI;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//
// Drives UART frames into uart_program_loader (CLK_DIV=16) and checks the
// program-memory writes it produces against a byte-level reference model.
// Expected writes and frame errors are queued when a byte is sent; a monitor
// process consumes them whenever the DUT strobes.

module tb_uart_program_loader;

  localparam int CLK_DIV = 16;
  localparam int AW      = 8;
  localparam int IW      = 4;
  localparam int DW      = AW + IW;

  logic          clk;
  logic          reset;
  logic          rx;
  logic          program_write;
  logic [DW-1:0] program_cmd;
  logic [AW-1:0] write_address;
  logic          loading;
  logic          frame_error;

  uart_program_loader #(
    .CLK_DIV          (CLK_DIV),
    .ADDR_WIDTH       (AW),
    .INSTRUCTION_WIDTH(IW),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .program_write(program_write),
    .program_cmd  (program_cmd),
    .write_address(write_address),
    .loading      (loading),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] cmd;
    logic [AW-1:0] addr;
  } wr_t;

  wr_t exp_q[$];
  int  exp_ferr;
  int  checks;
  int  failures;

  // Reference model of the loader at byte granularity.
  bit            m_phase_hi;
  logic [IW-1:0] m_op;
  int            m_addr;
  bit            m_loading;
  logic [DW-1:0] m_last_cmd;
  logic [AW-1:0] m_last_addr;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_phase_hi  = 1'b1;
    m_op        = '0;
    m_addr      = 0;
    m_loading   = 1'b0;
    m_last_cmd  = '0;
    m_last_addr = '0;
  endfunction

  function automatic void modelByte(input logic [7:0] b, input bit good);
    wr_t w;
    if (!good) begin
      exp_ferr++;
      m_phase_hi = 1'b1;
    end else if (m_phase_hi) begin
      if (b == 8'hFF) begin
        m_loading = 1'b0;
        m_addr    = 0;
      end else begin
        m_op       = b[IW-1:0];
        m_loading  = 1'b1;
        m_phase_hi = 1'b0;
      end
    end else begin
      w.cmd       = {m_op, b[AW-1:0]};
      w.addr      = AW'(m_addr);
      exp_q.push_back(w);
      m_last_cmd  = w.cmd;
      m_last_addr = w.addr;
      m_addr      = (m_addr + 1) % (1 << AW);
      m_phase_hi  = 1'b1;
    end
  endfunction

  task automatic holdLine(input logic level, input int cycles);
    rx = level;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkQuiescent(input string tag);
    @(negedge clk);
    checkOutput({tag, "_loading"}, {31'b0, loading}, {31'b0, m_loading});
    checkOutput({tag, "_cmd_hold"}, 32'(program_cmd), 32'(m_last_cmd));
    checkOutput({tag, "_addr_hold"}, 32'(write_address), 32'(m_last_addr));
  endtask

  task automatic checkResetValues(input string tag);
    @(negedge clk);
    checkOutput({tag, "_program_write"}, {31'b0, program_write}, 32'h0);
    checkOutput({tag, "_program_cmd"}, 32'(program_cmd), 32'h0);
    checkOutput({tag, "_write_address"}, 32'(write_address), 32'h0);
    checkOutput({tag, "_loading"}, {31'b0, loading}, 32'h0);
    checkOutput({tag, "_frame_error"}, {31'b0, frame_error}, 32'h0);
  endtask

  // Sends one 8N1 frame. abort_bit >= 0 pulses reset once that many data bits
  // have gone out, abandoning the frame.
  task automatic applyStimulus(input logic [7:0] b, input bit good_stop,
                               input int abort_bit, input int gap);
    if (abort_bit < 0) modelByte(b, good_stop);
    holdLine(1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        checkResetValues("abort_reset");
        return;
      end
      holdLine(b[i], CLK_DIV);
    end
    holdLine(good_stop, CLK_DIV);
    holdLine(1'b1, gap);
    checkQuiescent("byte");
  endtask

  task automatic sendWord(input logic [7:0] hi, input logic [7:0] lo);
    applyStimulus(hi, 1'b1, -1, 2);
    applyStimulus(lo, 1'b1, -1, 2);
  endtask

  // Monitor: every strobe or frame-error pulse must match the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (program_write) begin
        checkOutput("write_exclusive_of_ferr", {31'b0, frame_error}, 32'h0);
        checkOutput("write_expected", {31'b0, exp_q.size() > 0}, 32'h1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          checkOutput("program_cmd", 32'(program_cmd), 32'(e.cmd));
          checkOutput("write_address", 32'(write_address), 32'(e.addr));
          checkOutput("loading_during_write", {31'b0, loading}, 32'h1);
        end
      end
      if (frame_error) begin
        checkOutput("frame_error_expected", {31'b0, exp_ferr > 0}, 32'h1);
        if (exp_ferr > 0) exp_ferr--;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    exp_ferr = 0;
    modelReset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    checkResetValues("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    holdLine(1'b1, 10);

    // Single word.
    sendWord(8'h0A, 8'h5C);
    checkOutput("first_word_cmd", 32'(program_cmd), 32'hA5C);
    checkOutput("first_word_addr", 32'(write_address), 32'h0);

    // Three words, end marker, then a fresh download at address 0.
    // 0xFF in the LO position is ordinary data.
    sendWord(8'h13, 8'hFF);
    sendWord(8'hF7, 8'h42);
    applyStimulus(8'hFF, 1'b1, -1, 4);
    checkOutput("end_marker_loading", {31'b0, loading}, 32'h0);
    sendWord(8'h05, 8'h81);
    checkOutput("restart_addr", 32'(write_address), 32'h0);

    // Bad stop bit on a HI byte, then a good pair.
    applyStimulus(8'h09, 1'b0, -1, 4);
    sendWord(8'h06, 8'h3C);

    // Short glitch on the line, then a good pair.
    holdLine(1'b0, 4);
    holdLine(1'b1, 40);
    sendWord(8'h0E, 8'hA7);

    // Reset in the middle of the LO byte, then a pair at address 0.
    applyStimulus(8'h02, 1'b1, -1, 2);
    applyStimulus(8'h77, 1'b1, 3, 0);
    holdLine(1'b1, 20);
    sendWord(8'h0B, 8'hC3);
    checkOutput("post_reset_addr", 32'(write_address), 32'h0);

    // Randomised stream long enough to wrap the address counter.
    applyStimulus(8'hFF, 1'b1, -1, 2);
    for (int n = 0; n < 257; n++) begin
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'($urandom_range(0, 254));
      lo = 8'($urandom_range(0, 255));
      applyStimulus(hi, 1'b1, -1, $urandom_range(0, 3));
      applyStimulus(lo, 1'b1, -1, $urandom_range(0, 3));
      if (n == 255) checkOutput("wrap_last_addr", 32'(write_address), 32'hFF);
    end
    checkOutput("wrap_first_addr", 32'(write_address), 32'h00);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'h0);
    checkOutput("pending_frame_errors", 32'(exp_ferr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
